sme_stim_driver: RTL and testbench

- Synthesizable initiator for the SME string-match interface: the driving end of the chardata/isstring/ispattern protocol.
- A host loads a string (≤32 chars) and a pattern (≤8 chars) into internal buffers, then issues start.
- The block serializes the characters to the SME, waits for valid, and returns match/match_index or a timeout.
- Sits between a host controller (or on-chip BIST sequencer) and SME.

---
 rtl/sme_stim_driver.sv | 189 ++++++++++++++++++
 tb/tb_sme_stim_driver.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_stim_driver.sv
// Initiator for the SME string-match interface: buffers a string and a pattern,
// serializes them on chardata/isstring/ispattern and returns the SME result or a timeout.
module sme_stim_driver #(
  parameter int unsigned STR_MAX = 32,
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] str_len,
  input  logic [3:0] pat_len,
  input  logic       send_str,
  input  logic       start,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       busy,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  output logic       cmd_err
);

  localparam int unsigned SIW = $clog2(STR_MAX);
  localparam int unsigned PIW = $clog2(PAT_MAX);
  localparam int unsigned LW  = SIW + 1;
  localparam int unsigned TW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND_STR,
    S_SEND_PAT,
    S_WAIT
  } state_e;

  state_e        state_q;
  logic [LW-1:0] idx_q;
  logic [5:0]    str_len_q;
  logic [3:0]    pat_len_q;
  logic [TW-1:0] wcnt_q;

  logic [7:0] chardata_q;
  logic       isstring_q;
  logic       ispattern_q;
  logic       busy_q;
  logic       res_valid_q;
  logic       res_match_q;
  logic [4:0] res_index_q;
  logic       res_timeout_q;
  logic       cmd_err_q;

  logic [7:0] str_mem [STR_MAX];
  logic [7:0] pat_mem [PAT_MAX];

  logic       wr_ok_c;
  logic       start_ok_c;
  logic [7:0] str0_c;
  logic [7:0] pat0_c;
  logic [7:0] str_cur_c;
  logic [7:0] pat_cur_c;

  assign wr_ok_c    = wr_en && (state_q == S_IDLE);
  assign start_ok_c = (pat_len != 4'd0) && (pat_len <= 4'(PAT_MAX)) &&
                      (!send_str || ((str_len != 6'd0) && (str_len <= 6'(STR_MAX))));

  // Bypass so a start issued with a same-cycle write sees the new character 0.
  assign str0_c = (wr_ok_c && !wr_sel && (wr_addr[SIW-1:0] == SIW'(0))) ? wr_data : str_mem[0];
  assign pat0_c = (wr_ok_c &&  wr_sel && (wr_addr[PIW-1:0] == PIW'(0))) ? wr_data : pat_mem[0];

  assign str_cur_c = str_mem[idx_q[SIW-1:0]];
  assign pat_cur_c = pat_mem[idx_q[PIW-1:0]];

  // Character buffers; not reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      if (!wr_sel) str_mem[wr_addr[SIW-1:0]] <= wr_data;
      else         pat_mem[wr_addr[PIW-1:0]] <= wr_data;
    end
  end

  // Control FSM; idx_q always points at the next character to drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      str_len_q     <= '0;
      pat_len_q     <= '0;
      wcnt_q        <= '0;
      chardata_q    <= '0;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= '0;
      res_timeout_q <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (start_ok_c) begin
              str_len_q <= str_len;
              pat_len_q <= pat_len;
              idx_q     <= LW'(1);
              busy_q    <= 1'b1;
              if (send_str) begin
                state_q    <= S_SEND_STR;
                chardata_q <= str0_c;
                isstring_q <= 1'b1;
              end else begin
                state_q     <= S_SEND_PAT;
                chardata_q  <= pat0_c;
                ispattern_q <= 1'b1;
              end
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end
        S_SEND_STR: begin
          if (idx_q == str_len_q) begin
            state_q     <= S_SEND_PAT;
            chardata_q  <= pat_mem[0];
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b1;
            idx_q       <= LW'(1);
          end else begin
            chardata_q <= str_cur_c;
            idx_q      <= idx_q + LW'(1);
          end
        end
        S_SEND_PAT: begin
          if (idx_q == LW'(pat_len_q)) begin
            state_q     <= S_WAIT;
            chardata_q  <= '0;
            ispattern_q <= 1'b0;
            wcnt_q      <= '0;
          end else begin
            chardata_q <= pat_cur_c;
            idx_q      <= idx_q + LW'(1);
          end
        end
        S_WAIT: begin
          // A real answer takes priority over a coincident timeout.
          if (sme_valid) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b1;
            res_match_q   <= sme_match;
            res_index_q   <= sme_index;
            res_timeout_q <= 1'b0;
          end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b1;
            res_match_q   <= 1'b0;
            res_index_q   <= '0;
            res_timeout_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign chardata    = chardata_q;
  assign isstring    = isstring_q;
  assign ispattern   = ispattern_q;
  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign res_match   = res_match_q;
  assign res_index   = res_index_q;
  assign res_timeout = res_timeout_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_sme_stim_driver.sv
// Directed self-checking bench for sme_stim_driver (built with TIMEOUT = 16).
module tb_sme_stim_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, wr_sel;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic       send_str, start;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       sme_valid, sme_match;
  logic [4:0] sme_index;
  logic       busy, res_valid, res_match, res_timeout, cmd_err;
  logic [4:0] res_index;

  int checks = 0;
  int errors = 0;

  logic [7:0] sq[$];
  logic [7:0] pq[$];
  int         cap_cycles;
  bit         cap_bad;
  bit         cap_done;

  sme_stim_driver #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .str_len(str_len), .pat_len(pat_len), .send_str(send_str), .start(start),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .sme_valid(sme_valid), .sme_match(sme_match), .sme_index(sme_index),
    .busy(busy), .res_valid(res_valid), .res_match(res_match),
    .res_index(res_index), .res_timeout(res_timeout), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit sel, input int addr, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 5'(addr); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Records the character stream until both qualifiers are low (first WAIT cycle).
  task automatic capture();
    bit seen_p;
    seen_p = 1'b0;
    sq.delete(); pq.delete();
    cap_bad = 1'b0; cap_done = 1'b0; cap_cycles = 0;
    for (int c = 0; c < 100; c++) begin
      if (!isstring && !ispattern) begin
        cap_done = 1'b1;
        break;
      end
      if (isstring && ispattern) cap_bad = 1'b1;
      if (isstring) begin
        if (seen_p) cap_bad = 1'b1;
        sq.push_back(chardata);
      end
      if (ispattern) begin
        seen_p = 1'b1;
        pq.push_back(chardata);
      end
      cap_cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    str_len = '0; pat_len = '0; send_str = 1'b0; start = 1'b0;
    sme_valid = 1'b0; sme_match = 1'b0; sme_index = '0;
    tick(); tick();
    checks++;
    if ({chardata, isstring, ispattern, busy, res_valid, res_match, res_index, res_timeout, cmd_err} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got chardata=%h is=%b ip=%b busy=%b rv=%b rm=%b ri=%0d rt=%b ce=%b want all 0",
               chardata, isstring, ispattern, busy, res_valid, res_match, res_index, res_timeout, cmd_err);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 5; i++) load(1'b0, i, 8'(8'h41 + i));
    load(1'b1, 0, 8'h43);
    load(1'b1, 1, 8'h44);
    str_len = 6'd5; pat_len = 4'd2; send_str = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    capture();
    checks++;
    if (!cap_done || cap_bad || cap_cycles != 7) begin
      errors++; $display("FAIL basic_stream done=%b bad=%b cycles=%0d want 1 0 7", cap_done, cap_bad, cap_cycles);
    end
    checks++;
    if (sq.size() != 5 || pq.size() != 2) begin
      errors++; $display("FAIL basic_counts str=%0d pat=%0d want 5 2", sq.size(), pq.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sq[i] !== 8'(8'h41 + i)) begin
        errors++; $display("FAIL basic_str[%0d] got %h want %h", i, sq[i], 8'(8'h41 + i));
      end
    end
    checks++;
    if (pq[0] !== 8'h43 || pq[1] !== 8'h44) begin
      errors++; $display("FAIL basic_pat got %h %h want 43 44", pq[0], pq[1]);
    end
    checks++;
    if (chardata !== 8'h00 || busy !== 1'b1 || res_valid !== 1'b0) begin
      errors++; $display("FAIL basic_wait chardata=%h busy=%b rv=%b want 00 1 0", chardata, busy, res_valid);
    end
    sme_valid = 1'b1; sme_match = 1'b1; sme_index = 5'd2;
    tick();
    sme_valid = 1'b0; sme_match = 1'b0; sme_index = '0;
    checks++;
    if ({res_valid, res_match, res_index, res_timeout, busy} !== {1'b1, 1'b1, 5'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL basic_result rv=%b rm=%b ri=%0d rt=%b busy=%b want 1 1 2 0 0",
                         res_valid, res_match, res_index, res_timeout, busy);
    end
  endtask

  // Starts in the res_valid cycle of the previous run, writing pattern char 0 in the same cycle.
  task automatic test_back_to_back();
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 5'd0; wr_data = 8'h45;
    pat_len = 4'd1; send_str = 1'b0; str_len = 6'd40; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || res_match !== 1'b1 || cmd_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept rv=%b rm=%b ce=%b busy=%b want 0 1 0 1", res_valid, res_match, cmd_err, busy);
    end
    capture();
    checks++;
    if (!cap_done || cap_bad || cap_cycles != 1 || sq.size() != 0 || pq.size() != 1) begin
      errors++; $display("FAIL b2b_stream done=%b bad=%b cycles=%0d str=%0d pat=%0d want 1 0 1 0 1",
                         cap_done, cap_bad, cap_cycles, sq.size(), pq.size());
    end
    checks++;
    if (pq[0] !== 8'h45) begin errors++; $display("FAIL b2b_pat got %h want 45", pq[0]); end
    sme_valid = 1'b1; sme_match = 1'b1; sme_index = 5'd4;
    tick();
    sme_valid = 1'b0; sme_match = 1'b0; sme_index = '0;
    checks++;
    if ({res_valid, res_match, res_index, res_timeout} !== {1'b1, 1'b1, 5'd4, 1'b0}) begin
      errors++; $display("FAIL b2b_result rv=%b rm=%b ri=%0d rt=%b want 1 1 4 0", res_valid, res_match, res_index, res_timeout);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0 || res_index !== 5'd4 || res_match !== 1'b1) begin
      errors++; $display("FAIL b2b_hold rv=%b ri=%0d rm=%b want 0 4 1", res_valid, res_index, res_match);
    end
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 32; i++) load(1'b0, i, 8'(8'h20 + i));
    for (int i = 0; i < 8; i++)  load(1'b1, i, 8'(8'h60 + i));
    str_len = 6'd32; pat_len = 4'd8; send_str = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    capture();
    checks++;
    if (!cap_done || cap_bad || cap_cycles != 40 || sq.size() != 32 || pq.size() != 8) begin
      errors++; $display("FAIL max_stream done=%b bad=%b cycles=%0d str=%0d pat=%0d want 1 0 40 32 8",
                         cap_done, cap_bad, cap_cycles, sq.size(), pq.size());
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (sq[i] !== 8'(8'h20 + i)) begin errors++; $display("FAIL max_str[%0d] got %h want %h", i, sq[i], 8'(8'h20 + i)); end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (pq[i] !== 8'(8'h60 + i)) begin errors++; $display("FAIL max_pat[%0d] got %h want %h", i, pq[i], 8'(8'h60 + i)); end
    end
    // Busy: an invalid start and buffer writes must all be ignored.
    start = 1'b1; pat_len = 4'd0; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd5; wr_data = 8'hEE;
    tick();
    start = 1'b0; wr_sel = 1'b1; wr_addr = 5'd2;
    checks++;
    if (cmd_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL busy_start ce=%b busy=%b want 0 1", cmd_err, busy);
    end
    tick();
    wr_en = 1'b0;
    sme_valid = 1'b1; sme_match = 1'b1; sme_index = 5'd31;
    tick();
    sme_valid = 1'b0; sme_match = 1'b0; sme_index = '0;
    checks++;
    if ({res_valid, res_match, res_index, res_timeout} !== {1'b1, 1'b1, 5'd31, 1'b0}) begin
      errors++; $display("FAIL max_result rv=%b rm=%b ri=%0d rt=%b want 1 1 31 0", res_valid, res_match, res_index, res_timeout);
    end
    tick();
  endtask

  task automatic test_cmd_err();
    logic [3:0] v_pat [3] = '{4'd0, 4'd2, 4'd9};
    logic [5:0] v_str [3] = '{6'd5, 6'd33, 6'd5};
    bit         v_snd [3] = '{1'b1, 1'b1, 1'b0};
    for (int v = 0; v < 3; v++) begin
      pat_len = v_pat[v]; str_len = v_str[v]; send_str = v_snd[v]; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({cmd_err, busy, isstring, ispattern} !== 4'b1000) begin
        errors++; $display("FAIL cmderr_pulse[%0d] ce=%b busy=%b is=%b ip=%b want 1 0 0 0", v, cmd_err, busy, isstring, ispattern);
      end
      tick();
      checks++;
      if ({cmd_err, busy, isstring, ispattern} !== 4'b0000) begin
        errors++; $display("FAIL cmderr_after[%0d] ce=%b busy=%b is=%b ip=%b want 0 0 0 0", v, cmd_err, busy, isstring, ispattern);
      end
    end
  endtask

  task automatic test_timeout();
    int  k;
    bit  found;
    pat_len = 4'd2; send_str = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    sme_valid = 1'b1; sme_match = 1'b1; sme_index = 5'd7;
    tick();
    sme_valid = 1'b0; sme_match = 1'b0; sme_index = '0;
    tick();
    checks++;
    if (isstring !== 1'b0 || ispattern !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL to_wait is=%b ip=%b rv=%b busy=%b want 0 0 0 1", isstring, ispattern, res_valid, busy);
    end
    found = 1'b0;
    for (k = 0; k < 40; k++) begin
      if (res_valid) begin found = 1'b1; break; end
      tick();
    end
    checks++;
    if (!found || k != 16) begin
      errors++; $display("FAIL to_latency found=%b wait_cycle=%0d want 1 16", found, k);
    end
    checks++;
    if ({res_timeout, res_match, res_index, busy} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
      errors++; $display("FAIL to_result rt=%b rm=%b ri=%0d busy=%b want 1 0 0 0", res_timeout, res_match, res_index, busy);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    str_len = 6'd32; pat_len = 4'd8; send_str = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++;
    if (isstring !== 1'b1 || chardata !== 8'h22) begin
      errors++; $display("FAIL rst_mid_third is=%b chardata=%h want 1 22", isstring, chardata);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({isstring, ispattern, busy, chardata} !== 11'd0) begin
      errors++; $display("FAIL rst_mid_outputs is=%b ip=%b busy=%b chardata=%h want 0 0 0 00", isstring, ispattern, busy, chardata);
    end
    tick();
    str_len = 6'd32; pat_len = 4'd8; send_str = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    capture();
    checks++;
    if (!cap_done || cap_bad || sq.size() != 32 || pq.size() != 8) begin
      errors++; $display("FAIL readback_stream done=%b bad=%b str=%0d pat=%0d want 1 0 32 8", cap_done, cap_bad, sq.size(), pq.size());
    end
    checks++;
    if (sq[5] !== 8'h25 || pq[2] !== 8'h62) begin
      errors++; $display("FAIL readback_dropped_write str5=%h pat2=%h want 25 62", sq[5], pq[2]);
    end
    sme_valid = 1'b1; sme_match = 1'b0; sme_index = 5'd9;
    tick();
    sme_valid = 1'b0; sme_index = '0;
    checks++;
    if ({res_valid, res_match, res_index, res_timeout} !== {1'b1, 1'b0, 5'd9, 1'b0}) begin
      errors++; $display("FAIL readback_result rv=%b rm=%b ri=%0d rt=%b want 1 0 9 0", res_valid, res_match, res_index, res_timeout);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_max_len();
    test_cmd_err();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
